// File: rtl/kpt_stream_out.sv
// Keypoint readout engine: walks the per-layer keypoint memories and
// serialises headers plus {row, col} entries onto a valid/ready word stream.
module kpt_stream_out #(
    parameter int NUM_LAYERS = 2,
    parameter int ADDR_W     = 10,
    parameter int ROW_W      = 9,
    parameter int COL_W      = 10
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [NUM_LAYERS*(ADDR_W+1)-1:0] kpt_count,
    output logic                             mem_rd_en,
    output logic [2:0]                       mem_rd_layer,
    output logic [ADDR_W-1:0]                mem_rd_addr,
    input  logic [ROW_W+COL_W-1:0]           mem_rd_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [15:0]                      out_data,
    output logic                             out_last,
    output logic                             busy,
    output logic                             done
);

    localparam int CW = ADDR_W + 1;
    localparam int EW = ROW_W + COL_W;

    typedef logic [NUM_LAYERS-1:0][CW-1:0] cnt_arr_t;
    typedef enum logic [2:0] {IDLE, HDR, FETCH, ROW, COL, DONE} state_t;

    function automatic logic [CW-1:0] cnt_of(input cnt_arr_t a, input logic [2:0] l);
        cnt_of = '0;
        for (int k = 0; k < NUM_LAYERS; k++)
            if (l == 3'(k)) cnt_of = a[k];
    endfunction

    function automatic logic [15:0] hdr(input logic [2:0] l, input logic [CW-1:0] c);
        return {1'b1, l, 12'(c)};
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       layer_q, layer_d;
    logic [CW-1:0]    idx_q, idx_d;
    cnt_arr_t         cnt_q, cnt_d;
    logic [15:0]      col_q, col_d;
    logic [EW-1:0]    ent_q;
    logic             rd_pend_q;

    logic             rd_en_d, valid_d, last_d, busy_d, done_d, adv;
    logic [2:0]       rd_layer_d;
    logic [ADDR_W-1:0] rd_addr_d;
    logic [15:0]      data_d;

    logic [CW-1:0]    cur_cnt, nxt_cnt, in_cnt0, idx_inc;
    logic [2:0]       nxt_layer;
    logic             last_layer, accept;
    logic [EW-1:0]    ent;
    logic [15:0]      row_w, col_w;

    assign cur_cnt    = cnt_of(cnt_q, layer_q);
    assign nxt_layer  = layer_q + 3'd1;
    assign nxt_cnt    = cnt_of(cnt_q, nxt_layer);
    assign in_cnt0    = kpt_count[CW-1:0];
    assign last_layer = (layer_q == 3'(NUM_LAYERS - 1));
    assign accept     = out_valid && out_ready;
    assign idx_inc    = idx_q + CW'(1);
    // Entry arriving this cycle takes precedence over the held copy
    assign ent        = rd_pend_q ? mem_rd_data : ent_q;
    assign row_w      = 16'(ent[EW-1:COL_W]);
    assign col_w      = 16'(ent[COL_W-1:0]);

    always_comb begin
        state_d    = state_q;
        layer_d    = layer_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        col_d      = col_q;
        valid_d    = out_valid;
        data_d     = out_data;
        last_d     = out_last;
        rd_en_d    = 1'b0;
        rd_layer_d = mem_rd_layer;
        rd_addr_d  = mem_rd_addr;
        adv        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = cnt_arr_t'(kpt_count);
                    layer_d = 3'd0;
                    state_d = HDR;
                    valid_d = 1'b1;
                    data_d  = hdr(3'd0, in_cnt0);
                    last_d  = (NUM_LAYERS == 1) && (in_cnt0 == '0);
                    if (in_cnt0 != '0) begin
                        rd_en_d    = 1'b1;
                        rd_layer_d = 3'd0;
                        rd_addr_d  = '0;
                    end
                end
            end
            HDR: begin
                if (accept) begin
                    if (cur_cnt != '0) begin
                        state_d = FETCH;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            FETCH: begin
                state_d = ROW;
                idx_d   = '0;
                valid_d = 1'b1;
                data_d  = row_w;
                col_d   = col_w;
                last_d  = 1'b0;
                if (cur_cnt > CW'(1)) begin
                    rd_en_d    = 1'b1;
                    rd_layer_d = layer_q;
                    rd_addr_d  = ADDR_W'(1);
                end
            end
            ROW: begin
                if (accept) begin
                    state_d = COL;
                    data_d  = col_q;
                    last_d  = last_layer && (idx_inc == cur_cnt);
                end
            end
            COL: begin
                if (accept) begin
                    if (idx_inc < cur_cnt) begin
                        state_d = ROW;
                        idx_d   = idx_inc;
                        data_d  = row_w;
                        col_d   = col_w;
                        last_d  = 1'b0;
                        if (idx_q + CW'(2) < cur_cnt) begin
                            rd_en_d    = 1'b1;
                            rd_layer_d = layer_q;
                            rd_addr_d  = ADDR_W'(idx_q + CW'(2));
                        end
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Current layer finished: open the next layer or close the frame
        if (adv) begin
            if (last_layer) begin
                state_d = DONE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end else begin
                state_d = HDR;
                layer_d = nxt_layer;
                valid_d = 1'b1;
                data_d  = hdr(nxt_layer, nxt_cnt);
                last_d  = (nxt_layer == 3'(NUM_LAYERS - 1)) && (nxt_cnt == '0);
                if (nxt_cnt != '0) begin
                    rd_en_d    = 1'b1;
                    rd_layer_d = nxt_layer;
                    rd_addr_d  = '0;
                end
            end
        end
        busy_d = state_d inside {HDR, FETCH, ROW, COL};
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            layer_q      <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            col_q        <= '0;
            ent_q        <= '0;
            rd_pend_q    <= 1'b0;
            mem_rd_en    <= 1'b0;
            mem_rd_layer <= '0;
            mem_rd_addr  <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            layer_q      <= layer_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            col_q        <= col_d;
            rd_pend_q    <= mem_rd_en;
            if (rd_pend_q) ent_q <= mem_rd_data;
            mem_rd_en    <= rd_en_d;
            mem_rd_layer <= rd_layer_d;
            mem_rd_addr  <= rd_addr_d;
            out_valid    <= valid_d;
            out_data     <= data_d;
            out_last     <= last_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

endmodule

// File: tb/tb_kpt_stream_out.sv
// Directed bench for kpt_stream_out: frame contents, timing, backpressure,
// empty/full layers, mid-frame start/count changes and mid-frame reset.
module tb_kpt_stream_out;

    localparam int NL  = 2;
    localparam int AW  = 10;
    localparam int RW  = 9;
    localparam int CLW = 10;
    localparam int CW  = AW + 1;
    localparam int EW  = RW + CLW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [NL*CW-1:0]  kpt_count = '0;
    logic              mem_rd_en;
    logic [2:0]        mem_rd_layer;
    logic [AW-1:0]     mem_rd_addr;
    logic [EW-1:0]     mem_rd_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [15:0]       out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    kpt_stream_out #(.NUM_LAYERS(NL), .ADDR_W(AW), .ROW_W(RW), .COL_W(CLW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .kpt_count(kpt_count),
        .mem_rd_en(mem_rd_en), .mem_rd_layer(mem_rd_layer),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [EW-1:0] mem [NL][1<<AW];

    always_ff @(posedge clk)
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_layer[0]][mem_rd_addr];

    int vectors = 0;
    int errors = 0;
    int cyc = 0;
    int done_n, done_cyc, s;
    logic [16:0] got[$];
    logic [16:0] expw[$];
    int rd_q[$];
    int expr[$];
    int acc_cyc[$];
    logic busy_log[$];
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [15:0] pd = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (pv && !pr) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(pd));
            chk("stall_last", 32'(out_last), 32'(pl));
        end
        if (out_valid && out_ready) begin
            got.push_back({out_last, out_data});
            acc_cyc.push_back(cyc);
        end
        if (mem_rd_en) rd_q.push_back(int'(mem_rd_layer) * 4096 + int'(mem_rd_addr));
        if (done) begin
            done_n++;
            done_cyc = cyc;
            chk("done_busy", 32'(busy), 32'd0);
        end
        busy_log.push_back(busy);
        pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
        chk({tag, "_rd_layer"}, 32'(mem_rd_layer), 32'd0);
        chk({tag, "_rd_addr"}, 32'(mem_rd_addr), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"}, 32'(out_data), 32'd0);
        chk({tag, "_last"}, 32'(out_last), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic build_exp(input int c0, input int c1);
        logic [16:0] w;
        int c;
        expw.delete();
        expr.delete();
        for (int l = 0; l < NL; l++) begin
            c = (l == 0) ? c0 : c1;
            expw.push_back({1'b0, 16'h8000 | 16'(l << 12) | 16'(c)});
            for (int i = 0; i < c; i++) begin
                w = {1'b0, 16'(mem[l][i][EW-1:CLW])};
                expw.push_back(w);
                w = {1'b0, 16'(mem[l][i][CLW-1:0])};
                expw.push_back(w);
                expr.push_back(l * 4096 + i);
            end
        end
        w = expw.pop_back();
        w[16] = 1'b1;
        expw.push_back(w);
    endtask

    // Start a frame and run it; stop_at >= 0 abandons it after that many cycles.
    task automatic run_frame(input int c0, input int c1, input bit rnd,
                             input int disturb_at, input int stop_at, input int budget);
        got.delete(); acc_cyc.delete(); rd_q.delete(); busy_log.delete();
        done_n = 0;
        done_cyc = -1;
        kpt_count = {11'(c1), 11'(c0)};
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        s = cyc;
        start = 1'b0;
        for (int k = 0; k < budget && done_n == 0 && k != stop_at; k++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (k == disturb_at) begin
                start = 1'b1;
                kpt_count = {11'd1, 11'd1};
            end
            if (k == disturb_at + 1) start = 1'b0;
            tick();
        end
        out_ready = 1'b1;
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_nwords"}, 32'(got.size()), 32'(expw.size()));
        foreach (expw[i])
            if (i < got.size()) chk({tag, "_word"}, 32'(got[i]), 32'(expw[i]));
        chk({tag, "_nreads"}, 32'(rd_q.size()), 32'(expr.size()));
        foreach (expr[i])
            if (i < rd_q.size()) chk({tag, "_read"}, 32'(rd_q[i]), 32'(expr[i]));
        chk({tag, "_done_pulses"}, 32'(done_n), 32'd1);
    endtask

    initial begin
        for (int l = 0; l < NL; l++)
            for (int a = 0; a < (1 << AW); a++)
                mem[l][a] = {9'((a * 5 + l * 37) % 480), 10'((a * 3 + l * 11 + 1) % 640)};
        mem[0][0] = {9'd479, 10'd639};

        // Reset state
        repeat (2) tick();
        chk_zero("reset");
        rst_n = 1'b1;
        tick();

        // Counts {3,2}, ready held high
        run_frame(3, 2, 1'b0, -1, -1, 100);
        build_exp(3, 2);
        check_frame("f32");
        chk("f32_hdr0", 32'(got[0]), 32'h08003);
        chk("f32_row479", 32'(got[1]), 32'h001DF);
        chk("f32_col639", 32'(got[2]), 32'h0027F);
        chk("f32_hdr1", 32'(got[7]), 32'h09002);
        chk("f32_first_word", 32'(acc_cyc[0]), 32'(s + 1));
        chk("f32_bubble", 32'(acc_cyc[1]), 32'(s + 3));
        chk("f32_hdr1_cyc", 32'(acc_cyc[7]), 32'(s + 9));
        chk("f32_last_word", 32'(acc_cyc[11]), 32'(s + 14));
        chk("f32_done_cyc", 32'(done_cyc), 32'(s + 15));
        chk("f32_busy_idle", 32'(busy_log[0]), 32'd0);
        chk("f32_busy_run", 32'(busy_log[1]), 32'd1);

        // Both layers empty
        run_frame(0, 0, 1'b0, -1, -1, 20);
        build_exp(0, 0);
        check_frame("f00");
        chk("f00_hdr0", 32'(got[0]), 32'h08000);
        chk("f00_hdr1", 32'(got[1]), 32'h19000);
        chk("f00_cyc0", 32'(acc_cyc[0]), 32'(s + 1));
        chk("f00_cyc1", 32'(acc_cyc[1]), 32'(s + 2));
        chk("f00_done_cyc", 32'(done_cyc), 32'(s + 3));

        // Counts {4,0} under random backpressure
        run_frame(4, 0, 1'b1, -1, -1, 400);
        build_exp(4, 0);
        check_frame("f40");
        chk("f40_last_hdr", 32'(got[9]), 32'h19000);

        // Full layer 0 of 1024 entries
        run_frame(1024, 0, 1'b0, -1, -1, 2200);
        build_exp(1024, 0);
        check_frame("f1024");
        chk("f1024_hdr0", 32'(got[0]), 32'h08400);
        chk("f1024_last_addr", 32'(rd_q[1023]), 32'd1023);

        // start and kpt_count disturbed mid-frame
        run_frame(3, 2, 1'b0, 3, -1, 100);
        build_exp(3, 2);
        check_frame("fdist");
        repeat (3) tick();
        chk("fdist_idle_busy", 32'(busy), 32'd0);

        // Reset mid-entry in layer 1, then a fresh frame
        run_frame(3, 2, 1'b0, -1, 11, 100);
        chk("rst_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_async");
        pv = 1'b0;
        tick();
        chk_zero("rst_held");
        rst_n = 1'b1;
        tick();
        chk_zero("rst_released");
        run_frame(3, 2, 1'b0, -1, -1, 100);
        build_exp(3, 2);
        check_frame("frst");
        chk("frst_first_word", 32'(acc_cyc[0]), 32'(s + 1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
